// File: rtl/shifter_seq.sv
// Bit-serial shifter: accepts one SLL/SRL/SRA/pass operation per handshake and
// shifts one bit per clock, returning a result identical to the combinational shifter.
module shifter_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] r_next;
  logic [SHW-1:0]   count;
  logic [SHW-1:0]   count_next;
  logic [1:0]       op;
  logic [1:0]       op_next;

  // Accept only from IDLE, and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    r_next     = r;
    count_next = count;
    op_next    = op;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          r_next     = a;
          count_next = shamt;
          op_next    = op_type;
          if (shamt == '0 || op_type == OP_PASS) state_next = DONE;
          else                                   state_next = SHIFT;
        end
      end
      SHIFT: begin
        case (op)
          OP_SLL:  r_next = {r[WIDTH-2:0], 1'b0};
          OP_SRL:  r_next = {1'b0, r[WIDTH-1:1]};
          OP_SRA:  r_next = {r[WIDTH-1], r[WIDTH-1:1]};
          default: r_next = r;
        endcase
        count_next = count - SHW'(1);
        if (count == SHW'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      count     <= '0;
      op        <= OP_SLL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      r         <= r_next;
      count     <= count_next;
      op        <= op_next;
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Multi-cycle, bit-serial counterpart of the combinational shifter.
- Accepts one shift operation on a valid/ready input handshake and shifts one bit position per clock.
- Returns the result on a valid/ready output handshake.
- Intended for the area-reduced multi-cycle datapath variant; result encoding matches the combinational shifter bit-for-bit.

Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept an operation
- a  in  WIDTH  operand
- shamt  in  SHW  shift amount
- type  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through (r = a)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  WIDTH  result
- busy  out  1  operation in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (async, takes effect immediately): state=IDLE, r=0, count=0, type register=00, out_valid=0, busy=0. in_ready=0 while rst is high, 1 on the first cycle after release.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) & ~rst, combinational. out_valid = (state==DONE), registered. busy = (state!=IDLE).
- IDLE:
  - in_valid & in_ready at edge E0 captures r<=a, count<=shamt, op<=type.
  - If shamt==0 or type==11: go to DONE.
  - Else: go to SHIFT.
  - in_valid low: stay in IDLE; r holds its last value.
- SHIFT, one bit per edge:
  - SLL: r<=r<<1.
  - SRL: r<={0, r[W-1:1]}.
  - SRA: r<={r[W-1], r[W-1:1]}; the sign is repeatedly replicated, so the original sign is preserved.
  - count<=count-1. When count==1 at the edge, go to DONE.
- Latency: out_valid rises at edge E0+shamt (shamt=0 or pass-through: at E0 itself, i.e. visible the next cycle). Maximum is 31 edges.
- DONE:
  - r stable and out_valid=1 until out_ready is sampled high.
  - At that edge: out_valid<=0, go to IDLE.
  - No accept in DONE (in_ready=0). Minimum issue interval is shamt+2 cycles.
- Inputs a, shamt, type are ignored outside the accepting edge; changes during SHIFT/DONE have no effect.
- in_valid asserted while not ready: request is not consumed; the requester must hold it. No queuing.
- out_ready asserted outside DONE: ignored.
- rst asserted mid-SHIFT or in DONE: operation discarded, no out_valid pulse, outputs at reset values.
- Result equals the combinational shifter for all (a, shamt, type), including shamt=31 and type=11.

Test Plan:
- Reset then SLL: a=0x0000_0001, shamt=4, type=00 -> out_valid 4 edges after accept, r=0x0000_0010. in_ready low from accept until the edge after out_ready.
- SRA negative: a=0x8000_0000, shamt=31, type=10 -> r=0xFFFF_FFFF after 31 edges. The same operand with type=01 -> r=0x0000_0001.
- Zero shift and pass-through: a=0xDEAD_BEEF, shamt=0, type=00 -> r=0xDEAD_BEEF, out_valid the cycle after accept. a=0x1234_5678, shamt=7, type=11 -> r=0x1234_5678, out_valid the cycle after accept.
- Backpressure: SRL a=0xF000_0000, shamt=8, out_ready low for 5 cycles in DONE -> r=0x00F0_0000 held stable with out_valid=1 throughout. A second in_valid during this time is not accepted until return to IDLE.
- Reset mid-operation: start SLL shamt=20, assert rst at shift 10 -> r=0, out_valid=0, busy=0 immediately. After release, a new op a=0x3, shamt=1, SLL -> r=0x6.
- Randomized check: 1000 random (a, shamt, type) with random out_ready stalls -> r matches the combinational shifter model, and latency = shamt edges for types 00/01/10.
